// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings and helpers
// for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F_MUL    = 3'b000;
  localparam logic [2:0] F_MULH   = 3'b001;
  localparam logic [2:0] F_MULHSU = 3'b010;
  localparam logic [2:0] F_MULHU  = 3'b011;
  localparam logic [2:0] F_DIV    = 3'b100;
  localparam logic [2:0] F_DIVU   = 3'b101;
  localparam logic [2:0] F_REM    = 3'b110;
  localparam logic [2:0] F_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FAST,
    S_DONE
  } state_t;

  function automatic logic [XLEN_DEFAULT-1:0] cond_neg(
    input logic [XLEN_DEFAULT-1:0] x,
    input logic                    neg
  );
    return neg ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [XLEN_DEFAULT-1:0] abs_val(
    input logic [XLEN_DEFAULT-1:0] x,
    input logic                    sgn
  );
    return cond_neg(x, sgn & x[XLEN_DEFAULT-1]);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: radix-2 shift-add multiplier and
// restoring divider sharing one hi/lo register pair.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(XLEN + 1);

  state_t state, state_nx;

  logic [2:0]      op;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] a, b, hi, lo;
  logic            sa, sb;
  logic [CW-1:0]   cnt;

  logic            s1, s2, accept, ovf, fast, last;
  logic [XLEN-1:0] abs1, abs2;
  logic [XLEN:0]   msum, rsh, rdiff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] fin, fres;
  logic            div0;

  // operand signedness, accept and special-case detection
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    unique case (funct3)
      F_MUL, F_MULH, F_DIV, F_REM: begin
        s1 = 1'b1;
        s2 = 1'b1;
      end
      F_MULHSU: s1 = 1'b1;
      default: ;
    endcase
    abs1   = abs_val(rs1_data, s1);
    abs2   = abs_val(rs2_data, s2);
    accept = start & ((state == S_IDLE) | (state == S_DONE));
    ovf    = ((funct3 == F_DIV) | (funct3 == F_REM))
           & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
           & (&rs2_data);
    fast   = funct3[2] & ((rs2_data == '0) | ovf);
    last   = (cnt == CW'(XLEN));
  end

  // one iteration step plus final sign fix-up
  always_comb begin
    msum   = {1'b0, hi} + (lo[0] ? {1'b0, a} : '0);
    rsh    = {hi, lo[XLEN-1]};
    rdiff  = rsh - {1'b0, b};
    prod   = {hi, lo};
    prod_s = (sa ^ sb) ? -prod : prod;
    div0   = (b == '0);
    fin    = '0;
    fres   = '0;
    unique case (1'b1)
      op == F_MUL:                fin = prod_s[XLEN-1:0];
      !op[2] && op[1:0] != 2'b00: fin = prod_s[2*XLEN-1:XLEN];
      op[2] && op[1]:             fin = cond_neg(hi, sa);
      op[2] && !op[1]:            fin = cond_neg(lo, sa ^ sb);
    endcase
    unique case (1'b1)
      div0 && !op[1]:  fres = '1;
      div0 && op[1]:   fres = cond_neg(a, sa);
      !div0 && !op[1]: fres = {1'b1, {(XLEN-1){1'b0}}};
      !div0 && op[1]:  fres = '0;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // next state and status outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        done     = (state == S_DONE);
        state_nx = accept ? (fast ? S_FAST : S_CALC)
                          : S_IDLE;
      end
      S_CALC: begin
        busy = 1'b1;
        if (last) state_nx = S_DONE;
      end
      S_FAST: begin
        busy     = 1'b1;
        state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // operand capture, iteration and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      op     <= '0;
      rd_q   <= '0;
      a      <= '0;
      b      <= '0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      cnt    <= '0;
      result <= '0;
      rd_out <= '0;
    end else if (accept) begin
      op   <= funct3;
      rd_q <= rd_in;
      a    <= abs1;
      b    <= abs2;
      sa   <= s1 & rs1_data[XLEN-1];
      sb   <= s2 & rs2_data[XLEN-1];
      hi   <= '0;
      lo   <= funct3[2] ? abs1 : abs2;
      cnt  <= '0;
    end else if (state == S_CALC) begin
      if (!last) begin
        cnt <= cnt + CW'(1);
        if (!op[2]) begin
          hi <= msum[XLEN:1];
          lo <= {msum[0], lo[XLEN-1:1]};
        end else begin
          hi <= rdiff[XLEN] ? rsh[XLEN-1:0]
                            : rdiff[XLEN-1:0];
          lo <= {lo[XLEN-2:0], ~rdiff[XLEN]};
        end
      end else begin
        result <= fin;
        rd_out <= rd_q;
      end
    end else if (state == S_FAST) begin
      result <= fres;
      rd_out <= rd_q;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random checks of
// muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] exp_res;
  logic [4:0]  exp_rd;
  int          exp_lat;

  muldiv_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .funct3   (funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .rd_in    (rd_in),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .rd_out   (rd_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, want);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [2:0] f,
    input logic [31:0] x,
    input logic [31:0] y);
    longint sx, sy, ux, uy;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    case (f)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          return 32'h80000000;
        p = sx / sy; return p[31:0];
      end
      3'd5: begin
        if (y == 0) return 32'hFFFFFFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF)
          return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f,
    input logic [31:0] x,
    input logic [31:0] y);
    if (f >= 3'd4 && y == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) &&
        x == 32'h80000000 && y == 32'hFFFFFFFF)
      return 1;
    return 33;
  endfunction

  // called at a negedge; returns at the negedge after accept
  task automatic issue(input logic [2:0] f,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [4:0] rd);
    funct3   = f;
    rs1_data = x;
    rs2_data = y;
    rd_in    = rd;
    start    = 1'b1;
    exp_res  = ref_res(f, x, y);
    exp_rd   = rd;
    exp_lat  = ref_lat(f, x, y);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // n counts edges after the accept edge
  task automatic wait_done(input string tag,
                           input int poke);
    int n  = 0;
    int nb = 0;
    while (done !== 1'b1 && n <= 40) begin
      if (busy === 1'b1) nb++;
      if (n == poke) begin
        start    = 1'b1;
        funct3   = 3'($urandom);
        rs1_data = $urandom;
        rs2_data = $urandom;
        rd_in    = 5'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({tag, " latency"}, 32'(n), 32'(exp_lat));
    chk({tag, " busy_cycles"}, 32'(nb), 32'(exp_lat));
    chk({tag, " busy_at_done"}, {31'b0, busy}, 32'd0);
    chk({tag, " result"}, result, exp_res);
    chk({tag, " rd_out"}, {27'b0, rd_out}, {27'b0, exp_rd});
  endtask

  task automatic op(input string tag,
                    input logic [2:0] f,
                    input logic [31:0] x,
                    input logic [31:0] y,
                    input logic [4:0] rd);
    issue(f, x, y, rd);
    wait_done(tag, -1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] corner [6];
    int dh;
    corner[0] = 32'h0;
    corner[1] = 32'h1;
    corner[2] = 32'hFFFFFFFF;
    corner[3] = 32'h80000000;
    corner[4] = 32'h7FFFFFFF;
    corner[5] = 32'h7;

    rst = 1'b1; start = 1'b0; funct3 = '0;
    rs1_data = '0; rs2_data = '0; rd_in = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset rd_out", {27'b0, rd_out}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    op("mul", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    chk("mul value", result, 32'hFFFFFFEB);
    op("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1);
    chk("mulhu value", result, 32'hFFFFFFFE);
    op("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2);
    chk("mulh value", result, 32'h00000000);
    op("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3);
    chk("mulhsu value", result, 32'hFFFFFFFF);
    op("div", 3'd4, -32'sd7, 32'd2, 5'd4);
    chk("div value", result, 32'hFFFFFFFD);
    op("rem", 3'd6, -32'sd7, 32'd2, 5'd6);
    chk("rem value", result, 32'hFFFFFFFF);
    op("divu", 3'd5, 32'd100, 32'd7, 5'd7);
    chk("divu value", result, 32'd14);
    op("remu", 3'd7, 32'd100, 32'd7, 5'd8);
    chk("remu value", result, 32'd2);
    op("div0", 3'd4, 32'd5, 32'd0, 5'd9);
    chk("div0 value", result, 32'hFFFFFFFF);
    op("remu0", 3'd7, 32'd5, 32'd0, 5'd10);
    chk("remu0 value", result, 32'd5);
    op("divovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd11);
    chk("divovf value", result, 32'h80000000);
    op("removf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd12);
    chk("removf value", result, 32'h0);

    issue(3'd0, 32'd1234, 32'd5678, 5'd13);
    wait_done("midstart", 10);
    chk("midstart value", result, 32'd7006652);

    issue(3'd5, 32'd1000, 32'd3, 5'd14);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst busy", {31'b0, busy}, 32'd0);
    chk("midrst done", {31'b0, done}, 32'd0);
    chk("midrst result", result, 32'd0);
    chk("midrst rd_out", {27'b0, rd_out}, 32'd0);
    dh = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dh++;
    end
    chk("midrst no_done", 32'(dh), 32'd0);

    op("b2b mul", 3'd0, 32'd6, 32'd7, 5'd15);
    issue(3'd5, 32'd9, 32'd3, 5'd16);
    chk("b2b done_once", {31'b0, done}, 32'd0);
    chk("b2b no_bubble", {31'b0, busy}, 32'd1);
    wait_done("b2b divu", -1);
    chk("b2b divu value", result, 32'd3);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] x, y;
      x = ($urandom_range(0, 2) == 0)
        ? corner[$urandom_range(0, 5)] : $urandom;
      y = ($urandom_range(0, 2) == 0)
        ? corner[$urandom_range(0, 5)] : $urandom;
      op($sformatf("rand%0d", i),
         3'($urandom_range(0, 7)), x, y,
         5'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
